// File: rtl/cr_kme_ia_responder.sv
// cr_kme_ia_responder
// Indirect-access responder for KME key memories. Executes NOP/READ/WRITE/INIT
// commands from the IA register file against a single-port memory. Functional
// datapath reads share the same port and always win arbitration.

module cr_kme_ia_responder #(
    parameter int NUM_ENTRIES = 1024,
    parameter int DATA_WIDTH  = 64,
    parameter int RD_LATENCY  = 1,
    localparam int AW         = $clog2(NUM_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // IA command side (register file)
    input  logic                  i_cmnd_stb,
    input  logic [3:0]            i_cmnd_op,
    input  logic [AW-1:0]         i_cmnd_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_dat,
    output logic [2:0]            o_stat_code,
    output logic [4:0]            o_stat_datawords,
    output logic [AW-1:0]         o_stat_addr,
    output logic [3:0]            o_capability_type,
    output logic [15:0]           o_capability_lst,
    output logic [DATA_WIDTH-1:0] o_rd_dat,

    // Functional read port (datapath)
    input  logic                  i_func_rd,
    input  logic [AW-1:0]         i_func_addr,
    output logic                  o_func_rd_vld,
    output logic [DATA_WIDTH-1:0] o_func_rd_dat,

    // Memory port
    output logic                  o_mem_cs,
    output logic                  o_mem_we,
    output logic [AW-1:0]         o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdat,
    input  logic [DATA_WIDTH-1:0] i_mem_rdat
);

    // Opcodes
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_READ  = 4'd1;
    localparam logic [3:0] OP_WRITE = 4'd2;
    localparam logic [3:0] OP_INIT  = 4'd3;

    // Status codes
    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_BUSY     = 3'd1;
    localparam logic [2:0] ST_ERR_ADDR = 3'd2;
    localparam logic [2:0] ST_ERR_OP   = 3'd3;

    // FSM states
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ISSUE    = 2'd1;
    localparam logic [1:0] S_WAIT_RD  = 2'd2;
    localparam logic [1:0] S_INIT_RUN = 2'd3;

    // Bit n set: opcode n supported. Also drives the capability output.
    localparam logic [15:0] CAP_LST = 16'h000F;

    // Command context
    logic [1:0]            r_state;
    logic                  r_is_rd;
    logic [AW-1:0]         r_addr;
    logic [DATA_WIDTH-1:0] r_wdat;
    logic [AW-1:0]         r_cnt;

    // Register-file facing results
    logic [2:0]            r_stat_code;
    logic [AW-1:0]         r_stat_addr;
    logic [DATA_WIDTH-1:0] r_rd_dat;

    // Registered memory port
    logic                  r_mem_cs;
    logic                  r_mem_we;
    logic [AW-1:0]         r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdat;

    // Completion of the final write of a WRITE/INIT, aligned with its mem_cs
    logic                  r_wr_done;

    // Per-beat requester tags; bit 0 is aligned with mem_cs, bit RD_LATENCY
    // with the cycle the memory returns data for that access.
    logic [RD_LATENCY:0]   r_tag_func;
    logic [RD_LATENCY:0]   r_tag_ia;

    // Port arbitration decision (registered into the mem_* stage)
    logic                  w_dec_cs;
    logic                  w_dec_we;
    logic [AW-1:0]         w_dec_addr;
    logic [DATA_WIDTH-1:0] w_dec_wdat;
    logic                  w_dec_func;
    logic                  w_dec_ia_rd;
    logic                  w_dec_last_wr;

    logic                  w_op_supported;
    logic                  w_op_addressed;
    logic                  w_addr_oob;
    logic                  w_cnt_last;
    logic                  w_ia_rd_ret;

    // Command validation on the raw strobe inputs
    assign w_op_supported = CAP_LST[i_cmnd_op];
    assign w_op_addressed = (i_cmnd_op == OP_READ) || (i_cmnd_op == OP_WRITE);
    assign w_addr_oob     = ({1'b0, i_cmnd_addr} >= (AW+1)'(NUM_ENTRIES));
    assign w_cnt_last     = (r_cnt == AW'(NUM_ENTRIES - 1));
    assign w_ia_rd_ret    = r_tag_ia[RD_LATENCY];

    // Memory port arbitration: functional read first, then the IA engine
    always_comb begin
        w_dec_cs      = 1'b0;
        w_dec_we      = 1'b0;
        w_dec_addr    = '0;
        w_dec_wdat    = '0;
        w_dec_func    = 1'b0;
        w_dec_ia_rd   = 1'b0;
        w_dec_last_wr = 1'b0;
        if (i_func_rd) begin
            w_dec_cs   = 1'b1;
            w_dec_addr = i_func_addr;
            w_dec_func = 1'b1;
        end else if (r_state == S_ISSUE) begin
            w_dec_cs   = 1'b1;
            w_dec_addr = r_addr;
            if (r_is_rd) begin
                w_dec_ia_rd = 1'b1;
            end else begin
                w_dec_we      = 1'b1;
                w_dec_wdat    = r_wdat;
                w_dec_last_wr = 1'b1;
            end
        end else if (r_state == S_INIT_RUN) begin
            w_dec_cs      = 1'b1;
            w_dec_we      = 1'b1;
            w_dec_addr    = r_cnt;
            w_dec_wdat    = r_wdat;
            w_dec_last_wr = w_cnt_last;
        end
    end

    // Register the arbitration decision onto the memory port and tag pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_cs   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_wdat <= '0;
            r_wr_done  <= 1'b0;
            r_tag_func <= '0;
            r_tag_ia   <= '0;
        end else begin
            r_mem_cs   <= w_dec_cs;
            r_mem_we   <= w_dec_we;
            r_mem_addr <= w_dec_addr;
            r_mem_wdat <= w_dec_wdat;
            r_wr_done  <= w_dec_last_wr;
            r_tag_func <= {r_tag_func[RD_LATENCY-1:0], w_dec_func};
            r_tag_ia   <= {r_tag_ia[RD_LATENCY-1:0], w_dec_ia_rd};
        end
    end

    // Command FSM: accept, issue, wait for read data, or sweep INIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_is_rd     <= 1'b0;
            r_addr      <= '0;
            r_wdat      <= '0;
            r_cnt       <= '0;
            r_stat_code <= ST_OK;
            r_stat_addr <= '0;
            r_rd_dat    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmnd_stb) begin
                        r_is_rd     <= (i_cmnd_op == OP_READ);
                        r_addr      <= i_cmnd_addr;
                        r_wdat      <= i_wr_dat;
                        r_stat_addr <= i_cmnd_addr;
                        if (!w_op_supported) begin
                            r_stat_code <= ST_ERR_OP;
                        end else if (w_op_addressed && w_addr_oob) begin
                            r_stat_code <= ST_ERR_ADDR;
                        end else if (i_cmnd_op == OP_NOP) begin
                            r_stat_code <= ST_OK;
                        end else begin
                            r_stat_code <= ST_BUSY;
                            r_cnt       <= '0;
                            r_state     <= (i_cmnd_op == OP_INIT) ? S_INIT_RUN : S_ISSUE;
                        end
                    end else if (r_wr_done) begin
                        // Status clears once the last write has reached the port
                        r_stat_code <= ST_OK;
                    end
                end
                S_ISSUE: begin
                    if (!i_func_rd) begin
                        r_state <= r_is_rd ? S_WAIT_RD : S_IDLE;
                    end
                end
                S_WAIT_RD: begin
                    if (w_ia_rd_ret) begin
                        r_rd_dat    <= i_mem_rdat;
                        r_stat_code <= ST_OK;
                        r_state     <= S_IDLE;
                    end
                end
                S_INIT_RUN: begin
                    if (!i_func_rd) begin
                        r_stat_addr <= r_cnt;
                        r_cnt       <= r_cnt + AW'(1);
                        if (w_cnt_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output mapping
    assign o_stat_code       = r_stat_code;
    assign o_stat_datawords  = 5'((DATA_WIDTH + 31) / 32 - 1);
    assign o_stat_addr       = r_stat_addr;
    assign o_capability_type = 4'h0;
    assign o_capability_lst  = CAP_LST;
    assign o_rd_dat          = r_rd_dat;

    assign o_func_rd_vld     = r_tag_func[RD_LATENCY];
    assign o_func_rd_dat     = r_tag_func[RD_LATENCY] ? i_mem_rdat : '0;

    assign o_mem_cs          = r_mem_cs;
    assign o_mem_we          = r_mem_we;
    assign o_mem_addr        = r_mem_addr;
    assign o_mem_wdat        = r_mem_wdat;

endmodule

// File: tb/tb_cr_kme_ia_responder.sv
// Bench for cr_kme_ia_responder: table-driven IA commands plus INIT, overlap
// and reset sequences; functional reads are checked through a scoreboard.

module tb_cr_kme_ia_responder;

    localparam int N   = 200;
    localparam int DW  = 64;
    localparam int LAT = 3;
    localparam int AW  = 8;

    localparam logic [3:0] OP_NOP = 4'd0, OP_RD = 4'd1, OP_WR = 4'd2, OP_INIT = 4'd3;

    localparam logic [63:0] V_A5 = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] V_5A = 64'h5A5A_5A5A_5A5A_5A5A;
    localparam logic [63:0] V_3C = 64'h3C3C_3C3C_3C3C_3C3C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmnd_stb = 1'b0;
    logic [3:0]    cmnd_op = '0;
    logic [AW-1:0] cmnd_addr = '0;
    logic [DW-1:0] wr_dat = '0;
    logic [2:0]    stat_code;
    logic [4:0]    stat_datawords;
    logic [AW-1:0] stat_addr;
    logic [3:0]    cap_type;
    logic [15:0]   cap_lst;
    logic [DW-1:0] rd_dat;
    logic          func_rd = 1'b0;
    logic [AW-1:0] func_addr = '0;
    logic          func_rd_vld;
    logic [DW-1:0] func_rd_dat;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdat;
    logic [DW-1:0] mem_rdat;

    always #5 clk = ~clk;

    cr_kme_ia_responder #(.NUM_ENTRIES(N), .DATA_WIDTH(DW), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmnd_stb(cmnd_stb), .i_cmnd_op(cmnd_op), .i_cmnd_addr(cmnd_addr), .i_wr_dat(wr_dat),
        .o_stat_code(stat_code), .o_stat_datawords(stat_datawords), .o_stat_addr(stat_addr),
        .o_capability_type(cap_type), .o_capability_lst(cap_lst), .o_rd_dat(rd_dat),
        .i_func_rd(func_rd), .i_func_addr(func_addr), .o_func_rd_vld(func_rd_vld),
        .o_func_rd_dat(func_rd_dat),
        .o_mem_cs(mem_cs), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdat(mem_wdat),
        .i_mem_rdat(mem_rdat)
    );

    // Memory model: single port, read data valid LAT cycles after the mem_cs cycle
    logic [DW-1:0] tb_mem [N];
    logic [DW-1:0] rd_pipe [LAT];
    logic          preload = 1'b0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < N; i++) tb_mem[i] <= {32'hC0DE_0000, 32'(i)};
        end else if (mem_cs && mem_we) begin
            tb_mem[mem_addr] <= mem_wdat;
        end
        if (mem_cs && !mem_we) rd_pipe[0] <= tb_mem[mem_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdat = rd_pipe[LAT-1];

    // Expected contents, maintained from the commands the bench issues
    logic [DW-1:0] model [N];

    int n_checks = 0;
    int n_pass   = 0;
    int cs_count = 0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Scoreboard consumer for functional reads, plus mem_cs activity counter
    initial begin
        logic [DW-1:0] fe;
        forever begin
            @(negedge clk);
            if (mem_cs) cs_count++;
            if (func_rd_vld) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL func_rd_unexpected: got %h expected no beat", func_rd_dat);
                end else begin
                    fe = exp_q.pop_front();
                    chk("func_rd_dat", func_rd_dat, fe);
                end
            end
        end
    end

    // Issue one command and wait until the status is no longer BUSY
    task automatic run_cmd(input logic [3:0] op, input logic [AW-1:0] addr, input logic [63:0] wd,
                           output logic [2:0] first, output int n);
        @(posedge clk); #1;
        cmnd_stb = 1'b1; cmnd_op = op; cmnd_addr = addr; wr_dat = wd;
        @(posedge clk); #1;
        cmnd_stb = 1'b0;
        n = 0;
        first = '0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) first = stat_code;
        end while (stat_code == 3'd1 && n < 3000);
    endtask

    task automatic strobe(input logic [3:0] op, input logic [AW-1:0] addr, input logic [63:0] wd);
        @(posedge clk); #1;
        cmnd_stb = 1'b1; cmnd_op = op; cmnd_addr = addr; wr_dat = wd;
        @(posedge clk); #1;
        cmnd_stb = 1'b0;
    endtask

    task automatic sweep(input int lo, input int hi);
        @(posedge clk); #1;
        for (int a = lo; a <= hi; a++) begin
            func_rd = 1'b1; func_addr = AW'(a);
            exp_q.push_back(model[a]);
            @(posedge clk); #1;
        end
        func_rd = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    typedef struct {
        logic [3:0]    op;
        logic [AW-1:0] addr;
        logic [63:0]   wdat;
        logic [2:0]    exp_first;
        logic [2:0]    exp_stat;
        int            exp_lat;
        logic [63:0]   exp_rd;
        logic [AW-1:0] exp_saddr;
        int            exp_cs;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [2:0] first;
        int n, cs0, kend, s, w, wb, cyc;
        logic [DW-1:0] fe;
        logic done;

        vecs[0]  = '{OP_WR,   8'd5,   64'hDEAD_BEEF_0123_4567, 3'd1, 3'd0, 3,       64'h0,                   8'd5,   1};
        vecs[1]  = '{OP_RD,   8'd5,   64'h0,                   3'd1, 3'd0, 3 + LAT, 64'hDEAD_BEEF_0123_4567, 8'd5,   1};
        vecs[2]  = '{OP_WR,   8'd199, 64'h0123_4567_89AB_CDEF, 3'd1, 3'd0, 3,       64'hDEAD_BEEF_0123_4567, 8'd199, 1};
        vecs[3]  = '{OP_RD,   8'd199, 64'h0,                   3'd1, 3'd0, 3 + LAT, 64'h0123_4567_89AB_CDEF, 8'd199, 1};
        vecs[4]  = '{OP_RD,   8'd200, 64'h0,                   3'd2, 3'd2, 1,       64'h0123_4567_89AB_CDEF, 8'd200, 0};
        vecs[5]  = '{4'd7,    8'd3,   64'h0,                   3'd3, 3'd3, 1,       64'h0123_4567_89AB_CDEF, 8'd3,   0};
        vecs[6]  = '{OP_WR,   8'd250, 64'h1,                   3'd2, 3'd2, 1,       64'h0123_4567_89AB_CDEF, 8'd250, 0};
        vecs[7]  = '{OP_NOP,  8'd12,  64'h0,                   3'd0, 3'd0, 1,       64'h0123_4567_89AB_CDEF, 8'd12,  0};
        vecs[8]  = '{4'd15,   8'd0,   64'h0,                   3'd3, 3'd3, 1,       64'h0123_4567_89AB_CDEF, 8'd0,   0};
        vecs[9]  = '{OP_RD,   8'd0,   64'h0,                   3'd1, 3'd0, 3 + LAT, 64'hC0DE_0000_0000_0000, 8'd0,   1};
        vecs[10] = '{OP_RD,   8'd7,   64'h0,                   3'd1, 3'd0, 3 + LAT, 64'hC0DE_0000_0000_0007, 8'd7,   1};

        for (int i = 0; i < N; i++) model[i] = {32'hC0DE_0000, 32'(i)};

        // Reset state and constants
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
        @(negedge clk);
        chk("rst_stat_code", 64'(stat_code), 64'd0);
        chk("rst_stat_addr", 64'(stat_addr), 64'd0);
        chk("rst_rd_dat", rd_dat, 64'd0);
        chk("rst_mem_cs", 64'(mem_cs), 64'd0);
        chk("rst_func_vld", 64'(func_rd_vld), 64'd0);
        chk("datawords", 64'(stat_datawords), 64'd1);
        chk("cap_type", 64'(cap_type), 64'h0);
        chk("cap_lst", 64'(cap_lst), 64'h000F);
        rst_n = 1'b1;

        // Table-driven single commands
        for (int i = 0; i < 11; i++) begin
            cs0 = cs_count;
            run_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdat, first, n);
            $display("vec %0d op=%0d addr=%0d stat=%0d lat=%0d rd_dat=%h", i, vecs[i].op,
                     vecs[i].addr, stat_code, n, rd_dat);
            chk($sformatf("v%0d_first_stat", i), 64'(first), 64'(vecs[i].exp_first));
            chk($sformatf("v%0d_stat", i), 64'(stat_code), 64'(vecs[i].exp_stat));
            chk($sformatf("v%0d_lat", i), 64'(n), 64'(vecs[i].exp_lat));
            chk($sformatf("v%0d_rd_dat", i), rd_dat, vecs[i].exp_rd);
            chk($sformatf("v%0d_stat_addr", i), 64'(stat_addr), 64'(vecs[i].exp_saddr));
            chk($sformatf("v%0d_mem_cs", i), 64'(cs_count - cs0), 64'(vecs[i].exp_cs));
            if (vecs[i].op == OP_WR && vecs[i].exp_stat == 3'd0) model[vecs[i].addr] = vecs[i].wdat;
        end

        // INIT with A5 while func_rd is high every third cycle
        w = 0; s = 0; kend = 0;
        while (w < N) begin
            kend++;
            if (kend % 3 == 0) s++;
            else w++;
        end
        strobe(OP_INIT, '0, V_A5);
        n = 0; done = 1'b0;
        for (int kk = 1; kk < 3000 && !done; kk++) begin
            if (kk <= kend && kk % 3 == 0) begin
                wb = (kk - 1) - (kk - 1) / 3;
                if ((kk / 3) % 2 == 1) begin
                    func_addr = AW'(wb - 1); fe = V_A5;
                end else begin
                    func_addr = AW'(wb); fe = model[wb];
                end
                func_rd = 1'b1;
                exp_q.push_back(fe);
            end else begin
                func_rd = 1'b0;
            end
            @(negedge clk);
            if (stat_code != 3'd1) begin
                done = 1'b1; n = kk;
            end else begin
                @(posedge clk); #1;
            end
        end
        func_rd = 1'b0;
        $display("init_a5 lat=%0d stalls=%0d stat=%0d", n, s, stat_code);
        chk("init_a5_lat", 64'(n), 64'(N + 2 + s));
        chk("init_a5_stat_addr", 64'(stat_addr), 64'(N - 1));
        for (int i = 0; i < N; i++) model[i] = V_A5;
        sweep(0, N - 1);

        // WRITE strobe during INIT_RUN is ignored
        strobe(OP_INIT, '0, V_5A);
        repeat (20) @(posedge clk);
        #1;
        cmnd_stb = 1'b1; cmnd_op = OP_WR; cmnd_addr = 8'd9; wr_dat = 64'h1111_1111_1111_1111;
        @(posedge clk); #1;
        cmnd_stb = 1'b0;
        @(negedge clk);
        cyc = 22;
        chk("stb_ignored_busy", 64'(stat_code), 64'd1);
        do begin
            @(negedge clk);
            cyc++;
        end while (stat_code == 3'd1 && cyc < 3000);
        $display("init_5a lat=%0d stat=%0d", cyc, stat_code);
        chk("init_5a_lat", 64'(cyc), 64'(N + 2));
        for (int i = 0; i < N; i++) model[i] = V_5A;
        run_cmd(OP_RD, 8'd9, '0, first, n);
        $display("read 9 rd_dat=%h", rd_dat);
        chk("entry9_init_value", rd_dat, V_5A);

        // READ overlapped with functional reads in WAIT_RD
        run_cmd(OP_WR, 8'd5, 64'h1234_5678_9ABC_DEF0, first, n);
        run_cmd(OP_WR, 8'd7, 64'h0FED_CBA9_8765_4321, first, n);
        model[5] = 64'h1234_5678_9ABC_DEF0;
        model[7] = 64'h0FED_CBA9_8765_4321;
        strobe(OP_RD, 8'd5, '0);
        @(posedge clk); #1;
        func_rd = 1'b1; func_addr = 8'd7; exp_q.push_back(model[7]);
        @(posedge clk); #1;
        func_rd = 1'b1; func_addr = 8'd7; exp_q.push_back(model[7]);
        @(posedge clk); #1;
        func_rd = 1'b0;
        n = 3;
        do begin
            @(negedge clk);
            n++;
        end while (stat_code == 3'd1 && n < 3000);
        $display("overlap read lat=%0d rd_dat=%h", n, rd_dat);
        chk("overlap_rd_dat", rd_dat, model[5]);
        chk("overlap_lat", 64'(n), 64'(3 + LAT));
        repeat (LAT + 3) @(negedge clk);
        chk("overlap_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of INIT
        strobe(OP_INIT, '0, V_3C);
        n = 0;
        while (stat_addr != 8'd100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("init_reached_100", 64'(stat_addr), 64'd100);
        rst_n = 1'b0;
        #1;
        $display("reset mid-init stat=%0d stat_addr=%0d", stat_code, stat_addr);
        chk("midrst_stat_code", 64'(stat_code), 64'd0);
        chk("midrst_stat_addr", 64'(stat_addr), 64'd0);
        chk("midrst_rd_dat", rd_dat, 64'd0);
        chk("midrst_mem_cs", 64'(mem_cs), 64'd0);
        chk("midrst_mem_we", 64'(mem_we), 64'd0);
        chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
        chk("midrst_mem_wdat", mem_wdat, 64'd0);
        chk("midrst_func_vld", 64'(func_rd_vld), 64'd0);
        chk("midrst_func_dat", func_rd_dat, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) model[i] = V_3C;
        run_cmd(OP_RD, 8'd50, '0, first, n);
        $display("post-reset read 50 stat=%0d lat=%0d rd_dat=%h", stat_code, n, rd_dat);
        chk("postrst_first_stat", 64'(first), 64'd1);
        chk("postrst_rd_dat", rd_dat, V_3C);
        chk("postrst_lat", 64'(n), 64'(3 + LAT));
        sweep(0, 99);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
